adc_capture_fifo: RTL and testbench

Triggered capture buffer sitting directly downstream of one AD9648 channel-pair connection. It consumes the A/B sample buses and overrange flags produced for one converter. On a software or threshold trigger it captures a programmed number of sample pairs into an on-chip FIFO, converted to two's complement and packed into 32-bit words. The packed words are drained to the host-side readout over a valid/ready stream.

---
 rtl/adc_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/adc_capture_fifo.sv | 171 +++++++++++++++++
 tb/tb_adc_capture_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants, capture-state encoding and sample conversion helpers for adc_capture_fifo.
package adc_pkg;

  localparam int unsigned ADC_BIT_WIDTH = 14;
  localparam int unsigned CAP_LEN_W     = 16;
  localparam int unsigned SAMPLE_W      = 15;
  localparam int unsigned WORD_W        = 32;

  typedef logic [1:0] cap_state_t;

  localparam cap_state_t StIdle    = 2'd0;
  localparam cap_state_t StArmed   = 2'd1;
  localparam cap_state_t StCapture = 2'd2;
  localparam cap_state_t StDrain   = 2'd3;

  // Sign-extend the low w bits of raw to the full 15-bit sample width.
  function automatic logic signed [SAMPLE_W-1:0] sext15(input logic [SAMPLE_W-1:0] raw,
                                                        input int unsigned w);
    logic signed [SAMPLE_W-1:0] t;
    t = raw << (SAMPLE_W - w);
    return t >>> (SAMPLE_W - w);
  endfunction

  // Offset binary to two's complement: flip the sample MSB, then sign-extend.
  function automatic logic signed [SAMPLE_W-1:0] ob_to_s15(input logic [SAMPLE_W-1:0] raw,
                                                           input int unsigned w);
    logic [SAMPLE_W-1:0] msb;
    msb = 15'd1 << (w - 1);
    return sext15(raw ^ msb, w);
  endfunction

  function automatic logic [WORD_W-1:0] pack_pair(input logic                ovr_a,
                                                  input logic [SAMPLE_W-1:0] a,
                                                  input logic                ovr_b,
                                                  input logic [SAMPLE_W-1:0] b);
    return {ovr_a, a, ovr_b, b};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered output stage; the output register counts toward depth.
module sync_fifo #(
  parameter int unsigned width = 32,
  parameter int unsigned aw    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  output logic [width-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Depth = 1 << aw;
  localparam logic [aw:0] DepthCnt = (aw + 1)'(Depth);

  logic [width-1:0] mem_q [Depth];
  logic [aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [aw:0]      mem_cnt_q;
  logic             out_valid_q;
  logic [width-1:0] out_data_q;

  logic [aw:0] total;
  logic        pop, push, refill, mem_rd, bypass, mem_wr;

  assign total  = mem_cnt_q + (aw + 1)'(out_valid_q);
  assign full   = (total == DepthCnt);
  assign empty  = !out_valid_q;
  assign pop    = out_valid_q && rd_ready;
  // A full FIFO still accepts a write when the output word leaves in the same cycle.
  assign push   = wr_en && (!full || pop);
  assign refill = !out_valid_q || pop;
  assign mem_rd = refill && (mem_cnt_q != '0);
  assign bypass = refill && (mem_cnt_q == '0) && push;
  assign mem_wr = push && !bypass;

  assign rd_data  = out_data_q;
  assign rd_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (mem_rd) begin
        out_data_q  <= mem_q[rd_ptr_q];
        out_valid_q <= 1'b1;
        rd_ptr_q    <= rd_ptr_q + aw'(1);
      end else if (bypass) begin
        out_data_q  <= wr_data;
        out_valid_q <= 1'b1;
      end else if (refill) begin
        out_valid_q <= 1'b0;
      end

      if (mem_wr) begin
        wr_ptr_q <= wr_ptr_q + aw'(1);
      end

      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt_q <= mem_cnt_q + (aw + 1)'(1);
        2'b01:   mem_cnt_q <= mem_cnt_q - (aw + 1)'(1);
        default: mem_cnt_q <= mem_cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_fifo.sv
// Triggered capture of AD9648 A/B sample pairs into a FIFO, drained as packed 32-bit words.
module adc_capture_fifo
  import adc_pkg::*;
#(
  parameter int unsigned bit_width = ADC_BIT_WIDTH,
  parameter int unsigned fifo_aw   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_en,
  input  logic [bit_width-1:0] data_a,
  input  logic [bit_width-1:0] data_b,
  input  logic                 overrange_a,
  input  logic                 overrange_b,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig_src,
  input  logic [bit_width-1:0] trig_level,
  input  logic [CAP_LEN_W-1:0] capture_len,
  output logic [WORD_W-1:0]    m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  cap_state_t state_q, state_d;

  logic [CAP_LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, last_idx;
  logic signed [SAMPLE_W-1:0] lvl_q, lvl_d, prev_a_q, prev_a_d, cur_a;
  logic prev_valid_q, prev_valid_d;
  logic done_q, done_d, overflow_q, overflow_d;
  logic tag, trig_hit, drop, fifo_full, fifo_empty, pipe_idle;

  // Stage 1 holds the raw inputs plus the write tag decided by the FSM in the arrival cycle.
  logic                 s1_wr_q, s1_ovr_a_q, s1_ovr_b_q;
  logic [bit_width-1:0] s1_a_q, s1_b_q;
  logic                 s2_wr_q;
  logic [WORD_W-1:0]    s2_data_q;

  assign cur_a     = ob_to_s15(SAMPLE_W'(data_a), bit_width);
  assign trig_hit  = prev_valid_q && (prev_a_q < lvl_q) && (cur_a >= lvl_q);
  assign last_idx  = len_q - 16'd1;
  assign pipe_idle = !s1_wr_q && !s2_wr_q;
  assign drop      = s2_wr_q && fifo_full && !(m_valid && m_ready);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    lvl_d        = lvl_q;
    prev_a_d     = prev_a_q;
    prev_valid_d = prev_valid_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q || drop;
    tag          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          len_d        = capture_len;
          lvl_d        = sext15(SAMPLE_W'(trig_level), bit_width);
          overflow_d   = 1'b0;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
          if (capture_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (abort) begin
          state_d = StDrain;
        end else if (sample_en) begin
          prev_a_d     = cur_a;
          prev_valid_d = 1'b1;
          if (!trig_src || trig_hit) begin
            tag     = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = (cnt_q == last_idx) ? StDrain : StCapture;
          end
        end
      end
      StCapture: begin
        if (abort) begin
          state_d = StDrain;
        end else if (sample_en) begin
          tag   = 1'b1;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == last_idx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Tagged pairs still in the input pipeline belong to this capture.
        if (pipe_idle && fifo_empty) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      len_q        <= '0;
      lvl_q        <= '0;
      prev_a_q     <= '0;
      prev_valid_q <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      lvl_q        <= lvl_d;
      prev_a_q     <= prev_a_d;
      prev_valid_q <= prev_valid_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_wr_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ovr_a_q <= 1'b0;
      s1_ovr_b_q <= 1'b0;
      s2_wr_q    <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_wr_q    <= tag;
      s1_a_q     <= data_a;
      s1_b_q     <= data_b;
      s1_ovr_a_q <= overrange_a;
      s1_ovr_b_q <= overrange_b;
      s2_wr_q    <= s1_wr_q;
      s2_data_q  <= pack_pair(s1_ovr_a_q, ob_to_s15(SAMPLE_W'(s1_a_q), bit_width),
                              s1_ovr_b_q, ob_to_s15(SAMPLE_W'(s1_b_q), bit_width));
    end
  end

  sync_fifo #(
    .width (WORD_W),
    .aw    (fifo_aw)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (s2_wr_q),
    .wr_data  (s2_data_q),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .rd_ready (m_ready),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Randomised capture scenarios checked against a sample-list model of trigger and capture rules.
module tb_adc_capture_fifo;

  localparam int BW      = 14;
  localparam int AW      = 2;
  localparam int Depth   = 1 << AW;
  localparam int MaxStim = 64;
  localparam int Offset  = 1 << (BW - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en = 1'b0;
  logic [BW-1:0] data_a = '0, data_b = '0, trig_level = '0;
  logic          overrange_a = 1'b0, overrange_b = 1'b0;
  logic          arm = 1'b0, abort = 1'b0, trig_src = 1'b0, m_ready = 1'b0;
  logic [15:0]   capture_len = '0;
  logic [31:0]   m_data;
  logic          m_valid, busy, done, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          done_cnt;
  int          first_valid_cyc;

  logic          st_en[MaxStim];
  logic [BW-1:0] st_a[MaxStim], st_b[MaxStim];
  logic          st_oa[MaxStim], st_ob[MaxStim];
  int            st_len;
  int            abort_at;

  adc_capture_fifo #(
    .bit_width (BW),
    .fifo_aw   (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .data_a      (data_a),
    .data_b      (data_b),
    .overrange_a (overrange_a),
    .overrange_b (overrange_b),
    .arm         (arm),
    .abort       (abort),
    .trig_src    (trig_src),
    .trig_level  (trig_level),
    .capture_len (capture_len),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] enc(input int v);
    return BW'(v + Offset);
  endfunction

  function automatic logic ready_for(input int mode, input bit draining);
    if (mode == 0) return 1'b1;
    if (mode == 2) return draining;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Stream monitor: collects transfers, counts done pulses, checks hold-under-stall.
  initial begin
    logic        stall;
    logic [31:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) check("stall_hold", {m_valid, m_data}, {1'b1, held});
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) got_q.push_back(m_data);
        if (done) done_cnt++;
        stall = m_valid && !m_ready;
        held  = m_data;
      end
    end
  end

  // Reference: list enabled pairs seen before abort, locate trigger, take len pairs.
  task automatic build_expected(input logic src, input int len, input int level,
                                input int ready_mode, output int exp_ovf);
    int   va[$];
    int   vb[$];
    logic oa[$];
    logic ob[$];
    int   trig;
    int   n_cap;
    exp_q.delete();
    for (int c = 0; c < st_len; c++) begin
      if (c < abort_at && st_en[c]) begin
        va.push_back(int'(st_a[c]) - Offset);
        vb.push_back(int'(st_b[c]) - Offset);
        oa.push_back(st_oa[c]);
        ob.push_back(st_ob[c]);
      end
    end
    trig = -1;
    if (!src) begin
      if (va.size() > 0) trig = 0;
    end else begin
      for (int i = 1; i < va.size(); i++) begin
        if (va[i-1] < level && va[i] >= level) begin
          trig = i;
          break;
        end
      end
    end
    n_cap = 0;
    if (trig >= 0) begin
      for (int i = trig; i < va.size() && n_cap < len; i++) begin
        exp_q.push_back({oa[i], 15'(va[i]), ob[i], 15'(vb[i])});
        n_cap++;
      end
    end
    exp_ovf = 0;
    if (ready_mode == 2 && n_cap > Depth) begin
      exp_ovf = 1;
      while (exp_q.size() > Depth) void'(exp_q.pop_back());
    end
  endtask

  task automatic run_capture(input string name, input logic src, input int len,
                             input int level, input int ready_mode);
    int exp_ovf;
    int start_cyc;
    bit timed_out;
    int n_cmp;
    got_q.delete();
    done_cnt        = 0;
    first_valid_cyc = -1;
    start_cyc       = 0;
    arm         = 1'b1;
    capture_len = 16'(len);
    trig_src    = src;
    trig_level  = BW'(level);
    sample_en   = 1'b1;
    data_a      = BW'($urandom);
    data_b      = BW'($urandom);
    m_ready     = ready_for(ready_mode, 1'b0);
    tick();
    arm = 1'b0;
    for (int c = 0; c <= st_len; c++) begin
      if (c < st_len) begin
        sample_en   = st_en[c];
        data_a      = st_a[c];
        data_b      = st_b[c];
        overrange_a = st_oa[c];
        overrange_b = st_ob[c];
      end else begin
        sample_en = 1'b0;
      end
      abort   = (c == abort_at);
      m_ready = ready_for(ready_mode, 1'b0);
      if (c == 0) start_cyc = cyc;
      tick();
    end
    abort     = 1'b0;
    sample_en = 1'b0;
    build_expected(src, len, level, ready_mode, exp_ovf);
    if (ready_mode == 2) begin
      repeat (10) tick();
      check({name, ":held_no_done"}, done_cnt, 0);
      check({name, ":held_ovf"}, overflow, exp_ovf);
      check({name, ":held_busy"}, busy, 1);
    end
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      m_ready = ready_for(ready_mode, 1'b1);
      tick();
    end
    check({name, ":timeout"}, timed_out, 0);
    m_ready = 1'b1;
    repeat (3) tick();
    check({name, ":n_words"}, got_q.size(), exp_q.size());
    n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) begin
      check($sformatf("%s:w%0d", name, i), got_q[i], exp_q[i]);
    end
    check({name, ":done_cnt"}, done_cnt, 1);
    check({name, ":overflow"}, overflow, exp_ovf);
    if (ready_mode == 0 && !src && st_en[0] && abort_at > 0 && exp_q.size() > 0) begin
      check({name, ":latency"}, first_valid_cyc - start_cyc, 3);
    end
  endtask

  task automatic fill_sw();
    st_len   = 4;
    abort_at = st_len;
    for (int c = 0; c < st_len; c++) begin
      st_en[c] = 1'b1;
      st_a[c]  = BW'(14'h2000 + c);
      st_b[c]  = 14'h1FFF;
      st_oa[c] = 1'b0;
      st_ob[c] = 1'b0;
    end
  endtask

  task automatic fill_random(input logic src, input int n);
    st_len = n;
    for (int c = 0; c < st_len; c++) begin
      st_en[c] = ($urandom_range(0, 3) != 0);
      st_a[c]  = src ? enc(int'($urandom_range(0, 600)) - 300) : BW'($urandom);
      st_b[c]  = BW'($urandom);
      st_oa[c] = 1'($urandom);
      st_ob[c] = 1'($urandom);
    end
    abort_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, st_len - 1)) : st_len;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst:m_valid", m_valid, 0);
    check("rst:m_data", m_data, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:overflow", overflow, 0);
    rst_n = 1'b1;
    tick();

    fill_sw();
    run_capture("sw", 1'b0, 4, 0, 0);
    if (got_q.size() > 0) check("sw:first_word", got_q[0], 32'h0000_7FFF);

    st_len   = 42;
    abort_at = st_len;
    for (int c = 0; c < st_len; c++) begin
      st_en[c] = 1'b1;
      st_a[c]  = enc(-5 + 5 * c);
      st_b[c]  = BW'($urandom);
      st_oa[c] = 1'b0;
      st_ob[c] = 1'b0;
    end
    run_capture("thr", 1'b1, 6, 100, 0);
    if (got_q.size() > 0) check("thr:first_a", got_q[0][30:16], 15'd100);

    fill_random(1'b0, 12);
    for (int c = 0; c < st_len; c++) st_en[c] = 1'b1;
    abort_at = st_len;
    run_capture("ovf", 1'b0, 10, 0, 2);

    done_cnt = 0;
    got_q.delete();
    arm         = 1'b1;
    capture_len = 16'd0;
    trig_src    = 1'b0;
    m_ready     = 1'b1;
    sample_en   = 1'b1;
    check("zero:busy_arm", busy, 0);
    tick();
    arm = 1'b0;
    check("zero:done", done, 1);
    check("zero:busy", busy, 0);
    tick();
    sample_en = 1'b0;
    check("zero:done_clr", done, 0);
    check("zero:busy_after", busy, 0);
    repeat (5) tick();
    check("zero:words", got_q.size(), 0);
    check("zero:done_cnt", done_cnt, 1);

    fill_random(1'b0, 8);
    for (int c = 0; c < st_len; c++) st_en[c] = 1'b1;
    abort_at = 3;
    run_capture("abort", 1'b0, 10, 0, 0);
    check("abort:words3", got_q.size(), 3);

    got_q.delete();
    arm         = 1'b1;
    capture_len = 16'd10;
    trig_src    = 1'b0;
    m_ready     = 1'b0;
    tick();
    arm = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample_en = 1'b1;
      data_a    = BW'($urandom);
      data_b    = BW'($urandom);
      tick();
    end
    sample_en = 1'b0;
    check("rst_mid:pre_ovf", overflow, 1);
    check("rst_mid:pre_valid", m_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid:m_valid", m_valid, 0);
    check("rst_mid:busy", busy, 0);
    check("rst_mid:overflow", overflow, 0);
    check("rst_mid:m_data", m_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    fill_sw();
    run_capture("post_rst", 1'b0, 4, 0, 0);

    for (int it = 0; it < 25; it++) begin
      logic src;
      src = 1'($urandom);
      fill_random(src, 30);
      run_capture($sformatf("rnd%0d", it), src, int'($urandom_range(1, Depth)),
                  int'($urandom_range(0, 400)) - 200, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
